// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types and constants for the MEM-stage SRAM controller
package arm_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    localparam int MEM_BASE_DEFAULT = 1024;
    localparam int SRAM_AW          = 18;
    localparam int SRAM_DW          = 16;

endpackage

// File: rtl/sram_phase_counter.sv
// rtl/sram_phase_counter.sv - times one halfword phase of SRAM_WAIT cycles
module sram_phase_counter #(
    parameter int SRAM_WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int WIDTH = $clog2(SRAM_WAIT + 1);
    localparam logic [WIDTH-1:0] LAST_COUNT = WIDTH'(SRAM_WAIT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == LAST_COUNT);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - services 32-bit MEM-stage requests as two halfword SRAM accesses
module sram_controller
    import arm_mem_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int MEM_BASE  = MEM_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n
);

    mem_state_e  state;
    mem_state_e  state_next;
    logic        req;
    logic        phase_en;
    logic        phase_last;
    logic [31:0] addr_offset;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        is_write_q;
    logic        unused_addr_bits;

    assign req              = mem_r_en | mem_w_en;
    assign addr_offset      = address - 32'(MEM_BASE);
    assign unused_addr_bits = ^{addr_offset[31:19], addr_offset[1:0]};
    assign phase_en         = (state == LOW) || (state == HIGH);

    sram_phase_counter #(
        .SRAM_WAIT (SRAM_WAIT)
    ) u_phase_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (~phase_en | phase_last),
        .en   (phase_en),
        .last (phase_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // SRAM pins are loaded on the edge that enters each phase so they are stable for all of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            word_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        is_write_q  <= mem_w_en;
                        word_q      <= addr_offset[18:2];
                        wdata_q     <= write_data;
                        sram_addr   <= {addr_offset[18:2], 1'b0};
                        sram_dq_out <= mem_w_en ? write_data[15:0] : '0;
                        sram_dq_oe  <= mem_w_en;
                        sram_we_n   <= ~mem_w_en;
                    end
                end
                LOW: begin
                    if (phase_last) begin
                        if (!is_write_q) begin
                            read_data[15:0] <= sram_dq_in;
                        end
                        sram_addr   <= {word_q, 1'b1};
                        sram_dq_out <= is_write_q ? wdata_q[31:16] : '0;
                    end
                end
                HIGH: begin
                    if (phase_last) begin
                        if (!is_write_q) begin
                            read_data[31:16] <= sram_dq_in;
                        end
                        sram_dq_out <= '0;
                        sram_dq_oe  <= 1'b0;
                        sram_we_n   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - directed self-checking bench for sram_controller
module tb_sram_controller;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic [15:0] mem [0:262143];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sram_controller #(
        .SRAM_WAIT (W),
        .MEM_BASE  (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    // Asynchronous SRAM: reads are combinational, writes land while we_n is low.
    assign sram_dq_in = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_dq_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in an IDLE cycle, returns in the DONE cycle.
    task automatic run_op(input string tag, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [17:0] exp_sa, input logic [31:0] exp_rd);
        logic [15:0] exp_dq;
        mem_w_en   = wr;
        mem_r_en   = rd;
        address    = addr;
        write_data = wdata;
        #1;
        check({tag, ".req_ready"}, 32'(ready), 32'd0);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < W; c++) begin
                tick();
                if (ph == 0 && c == 0) begin
                    mem_w_en = 1'b0;
                    mem_r_en = 1'b0;
                end
                exp_dq = wr ? (ph == 1 ? wdata[31:16] : wdata[15:0]) : 16'h0000;
                check($sformatf("%s.p%0d.c%0d.addr", tag, ph, c), 32'(sram_addr), 32'(exp_sa | 18'(ph)));
                check($sformatf("%s.p%0d.c%0d.dq", tag, ph, c), 32'(sram_dq_out), 32'(exp_dq));
                check($sformatf("%s.p%0d.c%0d.oe", tag, ph, c), 32'(sram_dq_oe), 32'(wr));
                check($sformatf("%s.p%0d.c%0d.we_n", tag, ph, c), 32'(sram_we_n), 32'(!wr));
                check($sformatf("%s.p%0d.c%0d.ready", tag, ph, c), 32'(ready), 32'd0);
            end
        end
        tick();
        check({tag, ".done.ready"}, 32'(ready), 32'd1);
        check({tag, ".done.we_n"}, 32'(sram_we_n), 32'd1);
        check({tag, ".done.oe"}, 32'(sram_dq_oe), 32'd0);
        check({tag, ".done.dq"}, 32'(sram_dq_out), 32'd0);
        check({tag, ".done.addr_hold"}, 32'(sram_addr), 32'(exp_sa | 18'd1));
        check({tag, ".done.read_data"}, read_data, exp_rd);
    endtask

    initial begin
        rst        = 1'b1;
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b1;
        address    = 32'd1032;
        write_data = 32'hFFFF_FFFF;

        tick();
        tick();
        check("rst.we_n", 32'(sram_we_n), 32'd1);
        check("rst.oe", 32'(sram_dq_oe), 32'd0);
        check("rst.dq", 32'(sram_dq_out), 32'd0);
        check("rst.addr", 32'(sram_addr), 32'd0);
        check("rst.read_data", read_data, 32'd0);
        rst = 1'b0;
        #1;
        check("rel.ready_req", 32'(ready), 32'd0);
        mem_w_en = 1'b0;
        #1;
        check("rel.ready_idle", 32'(ready), 32'd1);
        tick();
        check("rel.still_idle_we_n", 32'(sram_we_n), 32'd1);
        check("rel.still_idle_ready", 32'(ready), 32'd1);

        run_op("wr1032", 1'b1, 1'b0, 32'd1032, 32'hDEAD_BEEF, 18'd4, 32'd0);
        check("wr1032.mem4", 32'(mem[4]), 32'h0000_BEEF);
        check("wr1032.mem5", 32'(mem[5]), 32'h0000_DEAD);
        tick();
        check("idle.ready", 32'(ready), 32'd1);
        run_op("rd1032", 1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'hDEAD_BEEF);

        tick();
        run_op("b2b_wr", 1'b1, 1'b0, 32'd1024, 32'h1234_5678, 18'd0, 32'hDEAD_BEEF);
        tick();
        run_op("b2b_rd", 1'b0, 1'b1, 32'd1027, 32'h0, 18'd0, 32'h1234_5678);

        tick();
        run_op("prio", 1'b1, 1'b1, 32'd1032, 32'h0BAD_F00D, 18'd4, 32'h1234_5678);
        check("prio.mem5", 32'(mem[5]), 32'h0000_0BAD);

        tick();
        run_op("wrap_wr", 1'b1, 1'b0, 32'd1020, 32'hCAFE_F00D, 18'h3FFFE, 32'h1234_5678);
        tick();
        run_op("wrap_rd", 1'b0, 1'b1, 32'd1020, 32'h0, 18'h3FFFE, 32'hCAFE_F00D);

        tick();
        mem_w_en   = 1'b1;
        address    = 32'd1032;
        write_data = 32'h55AA_33CC;
        tick();
        tick();
        tick();
        check("abort.high_addr", 32'(sram_addr), 32'd5);
        check("abort.high_we_n", 32'(sram_we_n), 32'd0);
        rst = 1'b1;
        tick();
        check("abort.we_n", 32'(sram_we_n), 32'd1);
        check("abort.oe", 32'(sram_dq_oe), 32'd0);
        check("abort.ready", 32'(ready), 32'd0);
        check("abort.read_data", read_data, 32'd0);
        check("abort.addr", 32'(sram_addr), 32'd0);
        rst      = 1'b0;
        mem_w_en = 1'b0;
        #1;
        check("abort.idle_ready", 32'(ready), 32'd1);
        tick();
        check("abort.idle_we_n", 32'(sram_we_n), 32'd1);
        check("abort.idle_ready2", 32'(ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
